// File: rtl/hazard_unit_md.sv
// -----------------------------------------------------------------------------
// hazard_unit_md
//   Hazard / forwarding controller for the 5-stage in-order pipeline
//   (F/D/E/M/W). It generates the stall and flush enables for the pipeline
//   registers, handles load-use and branch-in-D interlocks, and produces the
//   E-stage and D-stage forwarding selects. It also provides:
//     - an interlock FSM that holds a multi-cycle (mul/div) op in E for
//       MD_LAT cycles,
//     - an exception kill path,
//     - a saturating counter of fetch-stall cycles.
//
// Parameters
//   AW     register address width (register 0 reads as zero)
//   MD_LAT E-stage cycles a multi-cycle op occupies, 1..64
//   CNT_W  stall counter width
//
// Ports
//   clk, resetn              clock, asynchronous active-low reset
//   ra1D, ra2D               D-stage source registers
//   ra1E, ra2E               E-stage source registers
//   dstE, dstM, dstW         destination register per stage
//   wrE, wrM, wrW            stage writes a register
//   ldE, ldM                 stage holds a load
//   branchD                  D holds an operand-comparing branch
//   mdE                      E holds a multi-cycle op
//   i_wait, d_wait           I-cache / D-cache not ready
//   excp                     exception/redirect from M, kills younger stages
//   cnt_clr                  synchronous clear of stall_cnt
//   stallF..stallM           hold stage register
//   flushD..flushW           insert bubble into stage register
//   fwdaE, fwdbE             E operand select: 0 regfile, 1 from W, 2 from M
//   fwdaD, fwdbD             D branch operand forwarded from M
//   md_busy                  interlock FSM is in BUSY
//   stall_cnt                saturating count of cycles with stallF=1
// -----------------------------------------------------------------------------
module hazard_unit_md #(
   parameter int AW     = 5,
   parameter int MD_LAT = 3,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [AW-1:0]    ra1D,
   input  logic [AW-1:0]    ra2D,
   input  logic [AW-1:0]    ra1E,
   input  logic [AW-1:0]    ra2E,
   input  logic [AW-1:0]    dstE,
   input  logic [AW-1:0]    dstM,
   input  logic [AW-1:0]    dstW,
   input  logic             wrE,
   input  logic             wrM,
   input  logic             wrW,
   input  logic             ldE,
   input  logic             ldM,
   input  logic             branchD,
   input  logic             mdE,
   input  logic             i_wait,
   input  logic             d_wait,
   input  logic             excp,
   input  logic             cnt_clr,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             flushD,
   output logic             flushE,
   output logic             flushM,
   output logic             flushW,
   output logic [1:0]       fwdaE,
   output logic [1:0]       fwdbE,
   output logic             fwdaD,
   output logic             fwdbD,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   // Down-counter width: largest loaded value is MD_LAT-2 = 62.
   localparam int MCW = 6;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mdState_t;

   mdState_t         state, stateNext;
   logic [MCW-1:0]   mdCnt, mdCntNext;
   logic             mdStall;
   logic             loadUse, branchStall;
   logic             eHitD, mLoadHitD;

   // ---------------------------------------------------------------------------
   // Hazard detection terms
   // ---------------------------------------------------------------------------
   assign eHitD       = wrE && (dstE != '0) && ((dstE == ra1D) || (dstE == ra2D));
   assign mLoadHitD   = ldM && (dstM != '0) && ((dstM == ra1D) || (dstM == ra2D));
   assign loadUse     = ldE && eHitD;
   assign branchStall = branchD && (eHitD || mLoadHitD);

   // The md stall is asserted on the launch cycle in IDLE and on every BUSY
   // cycle with cnt!=0; the final BUSY cycle (cnt==0) lets E advance.
   assign mdStall = ((state == IDLE) && mdE && (MD_LAT > 1)) ||
                    ((state == BUSY) && (mdCnt != '0));

   // ---------------------------------------------------------------------------
   // Interlock FSM
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would create ordering races.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         mdCnt <= '0;
      end else begin
         state <= stateNext;
         mdCnt <= mdCntNext;
      end
   end

   // NOTE: every variable written in a combinational block gets a default
   // first, so no path can leave it unassigned and infer a latch.
   always_comb begin
      stateNext = state;
      mdCntNext = mdCnt;
      if (excp) begin
         stateNext = IDLE;
         mdCntNext = '0;
      end else begin
         unique case (state)
            IDLE: begin
               // Launch is deferred while the D-cache holds the pipe.
               if (mdE && !d_wait && (MD_LAT > 1)) begin
                  stateNext = BUSY;
                  mdCntNext = MCW'(MD_LAT - 2);
               end
            end
            BUSY: begin
               if (mdCnt != '0) begin
                  mdCntNext = mdCnt - 1'b1;
               end else if (!d_wait) begin
                  stateNext = IDLE;
               end
            end
            default: stateNext = IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Stall / flush / forward generation, priority ordered
   // ---------------------------------------------------------------------------
   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      stallM = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      flushM = 1'b0;
      flushW = 1'b0;
      fwdaE  = 2'd0;
      fwdbE  = 2'd0;
      fwdaD  = 1'b0;
      fwdbD  = 1'b0;

      if (!resetn) begin
         // Everything held at zero while reset is asserted.
      end else if (excp) begin
         flushD = 1'b1;
         flushE = 1'b1;
         flushM = 1'b1;
      end else if (d_wait) begin
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         stallM = 1'b1;
         flushW = 1'b1;
      end else begin
         // Forwarding is only meaningful when the pipe is not killed or frozen.
         if ((ra1E != '0) && (ra1E == dstM) && wrM)      fwdaE = 2'd2;
         else if ((ra1E != '0) && (ra1E == dstW) && wrW) fwdaE = 2'd1;
         if ((ra2E != '0) && (ra2E == dstM) && wrM)      fwdbE = 2'd2;
         else if ((ra2E != '0) && (ra2E == dstW) && wrW) fwdbE = 2'd1;
         // A load in M has no data yet, so it cannot feed the D comparator.
         fwdaD = (ra1D != '0) && (ra1D == dstM) && wrM && !ldM;
         fwdbD = (ra2D != '0) && (ra2D == dstM) && wrM && !ldM;

         if (mdStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
         end else if (i_wait) begin
            stallF = 1'b1;
            if (branchD) begin
               // Keep the branch in D and bubble E instead of dropping it.
               stallD = 1'b1;
               flushE = 1'b1;
            end else begin
               flushD = 1'b1;
            end
         end else if (loadUse || branchStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
         end
      end
   end

   assign md_busy = (state == BUSY);

   // ---------------------------------------------------------------------------
   // Saturating stall counter; clear wins over increment
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
      end else if (stallF && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_unit_md.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit_md
//   Self-checking bench for hazard_unit_md (MD_LAT=3, CNT_W=4). Each task
//   drives a scenario one cycle at a time, pushes the expected output vector
//   onto a scoreboard queue, and pops/compares it mid-cycle.
//   Output vector layout:
//   {stallF,stallD,stallE,stallM,flushD,flushE,flushM,flushW,fwdaE,fwdbE,
//    fwdaD,fwdbD,md_busy}
// -----------------------------------------------------------------------------
module tb_hazard_unit_md;

   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          resetn;
   logic [AW-1:0] ra1D, ra2D, ra1E, ra2E, dstE, dstM, dstW;
   logic          wrE, wrM, wrW, ldE, ldM, branchD, mdE;
   logic          i_wait, d_wait, excp, cnt_clr;
   logic          stallF, stallD, stallE, stallM;
   logic          flushD, flushE, flushM, flushW;
   logic [1:0]    fwdaE, fwdbE;
   logic          fwdaD, fwdbD, md_busy;
   logic [3:0]    stall_cnt;
   logic [14:0]   obsV;

   typedef struct {
      string       name;
      logic [14:0] v;
   } exp_t;

   typedef struct {
      string      name;
      logic [3:0] v;
   } cntExp_t;

   exp_t    sbQ[$];
   cntExp_t cntQ[$];
   int      nCmp = 0;
   int      nErr = 0;

   hazard_unit_md #(.AW(AW), .MD_LAT(3), .CNT_W(4)) dut (
      .clk(clk), .resetn(resetn),
      .ra1D(ra1D), .ra2D(ra2D), .ra1E(ra1E), .ra2E(ra2E),
      .dstE(dstE), .dstM(dstM), .dstW(dstW),
      .wrE(wrE), .wrM(wrM), .wrW(wrW), .ldE(ldE), .ldM(ldM),
      .branchD(branchD), .mdE(mdE), .i_wait(i_wait), .d_wait(d_wait),
      .excp(excp), .cnt_clr(cnt_clr),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
      .fwdaE(fwdaE), .fwdbE(fwdbE), .fwdaD(fwdaD), .fwdbD(fwdbD),
      .md_busy(md_busy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   assign obsV = {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW,
                  fwdaE, fwdbE, fwdaD, fwdbD, md_busy};

   function automatic logic [14:0] ev(input bit sF, sD, sE, sM, fD, fE, fM, fW,
                                      input bit [1:0] aE, bE,
                                      input bit aD, bD, busy);
      return {sF, sD, sE, sM, fD, fE, fM, fW, aE, bE, aD, bD, busy};
   endfunction

   task automatic clear_inputs();
      ra1D = '0; ra2D = '0; ra1E = '0; ra2E = '0;
      dstE = '0; dstM = '0; dstW = '0;
      wrE = 0; wrM = 0; wrW = 0; ldE = 0; ldM = 0;
      branchD = 0; mdE = 0; i_wait = 0; d_wait = 0; excp = 0; cnt_clr = 0;
   endtask

   // Reset forces every output low even with hazards present on the inputs.
   task automatic test_reset();
      exp_t e;
      clear_inputs();
      resetn = 1'b0;
      i_wait = 1; mdE = 1; ra1E = 7; dstM = 7; wrM = 1;
      repeat (2) @(negedge clk);
      sbQ.push_back('{"reset_outputs", ev(0,0,0,0,0,0,0,0,0,0,0,0,0)});
      #2;
      e = sbQ.pop_front();
      nCmp++;
      if (obsV !== e.v) begin
         nErr++;
         $display("FAIL %s: got %b want %b", e.name, obsV, e.v);
      end
      nCmp++;
      if (stall_cnt !== 4'd0) begin
         nErr++;
         $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
      end
      clear_inputs();
      @(negedge clk);
      resetn = 1'b1;
   endtask

   // Plain multi-cycle op: stall at t, t+1; released at t+2; IDLE at t+3.
   task automatic test_md_interlock();
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         case (i)
            0: begin mdE = 1; sbQ.push_back('{"md_t0", ev(1,1,1,0,0,0,1,0,0,0,0,0,0)}); end
            1: sbQ.push_back('{"md_t1", ev(1,1,1,0,0,0,1,0,0,0,0,0,1)});
            2: sbQ.push_back('{"md_t2", ev(0,0,0,0,0,0,0,0,0,0,0,0,1)});
            default: begin mdE = 0; sbQ.push_back('{"md_t3", ev(0,0,0,0,0,0,0,0,0,0,0,0,0)}); end
         endcase
         #2;
         e = sbQ.pop_front();
         nCmp++;
         if (obsV !== e.v) begin
            nErr++;
            $display("FAIL %s: got %b want %b", e.name, obsV, e.v);
         end
      end
   endtask

   // D-cache miss on the final BUSY cycle holds the FSM in BUSY.
   task automatic test_md_dwait();
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         case (i)
            0: begin mdE = 1; sbQ.push_back('{"mdw_t0", ev(1,1,1,0,0,0,1,0,0,0,0,0,0)}); end
            1: sbQ.push_back('{"mdw_t1", ev(1,1,1,0,0,0,1,0,0,0,0,0,1)});
            2: begin d_wait = 1; sbQ.push_back('{"mdw_dwait0", ev(1,1,1,1,0,0,0,1,0,0,0,0,1)}); end
            3: sbQ.push_back('{"mdw_dwait1", ev(1,1,1,1,0,0,0,1,0,0,0,0,1)});
            4: begin d_wait = 0; sbQ.push_back('{"mdw_release", ev(0,0,0,0,0,0,0,0,0,0,0,0,1)}); end
            default: begin mdE = 0; sbQ.push_back('{"mdw_idle", ev(0,0,0,0,0,0,0,0,0,0,0,0,0)}); end
         endcase
         #2;
         e = sbQ.pop_front();
         nCmp++;
         if (obsV !== e.v) begin
            nErr++;
            $display("FAIL %s: got %b want %b", e.name, obsV, e.v);
         end
      end
   endtask

   // Exception while BUSY with cnt=1 kills the op; next cycle is clean.
   task automatic test_excp();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         case (i)
            0: begin mdE = 1; sbQ.push_back('{"excp_launch", ev(1,1,1,0,0,0,1,0,0,0,0,0,0)}); end
            1: begin
               excp = 1; ra1E = 7; dstM = 7; wrM = 1;
               sbQ.push_back('{"excp_kill", ev(0,0,0,0,1,1,1,0,0,0,0,0,1)});
            end
            default: begin
               excp = 0; mdE = 0; ra1E = 0; dstM = 0; wrM = 0;
               sbQ.push_back('{"excp_after", ev(0,0,0,0,0,0,0,0,0,0,0,0,0)});
            end
         endcase
         #2;
         e = sbQ.pop_front();
         nCmp++;
         if (obsV !== e.v) begin
            nErr++;
            $display("FAIL %s: got %b want %b", e.name, obsV, e.v);
         end
      end
   endtask

   // Load-use and branch-in-D interlocks, including the r0 exemption.
   task automatic test_data_hazard();
      exp_t e;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         clear_inputs();
         case (i)
            0: begin
               ldE = 1; wrE = 1; dstE = 5; ra2D = 5;
               sbQ.push_back('{"lduse_hit", ev(1,1,0,0,0,1,0,0,0,0,0,0,0)});
            end
            1: begin
               ldE = 1; wrE = 1; dstE = 0; ra2D = 0;
               sbQ.push_back('{"lduse_r0", ev(0,0,0,0,0,0,0,0,0,0,0,0,0)});
            end
            2: begin
               branchD = 1; wrE = 1; dstE = 3; ra2D = 3;
               sbQ.push_back('{"br_alu_in_e", ev(1,1,0,0,0,1,0,0,0,0,0,0,0)});
            end
            3: begin
               branchD = 1; ldM = 1; wrM = 1; dstM = 6; ra1D = 6;
               sbQ.push_back('{"br_load_in_m", ev(1,1,0,0,0,1,0,0,0,0,0,0,0)});
            end
            default: begin
               wrE = 1; dstE = 3; ra2D = 3;
               sbQ.push_back('{"alu_no_branch", ev(0,0,0,0,0,0,0,0,0,0,0,0,0)});
            end
         endcase
         #2;
         e = sbQ.pop_front();
         nCmp++;
         if (obsV !== e.v) begin
            nErr++;
            $display("FAIL %s: got %b want %b", e.name, obsV, e.v);
         end
      end
   endtask

   // Forwarding selects: M over W, r0 never forwarded, suppressed on d_wait.
   task automatic test_forward();
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         clear_inputs();
         ra1E = 7; dstM = 7; wrM = 1; dstW = 7; wrW = 1;
         case (i)
            0: sbQ.push_back('{"fwdaE_m", ev(0,0,0,0,0,0,0,0,2,0,0,0,0)});
            1: begin wrM = 0; sbQ.push_back('{"fwdaE_w", ev(0,0,0,0,0,0,0,0,1,0,0,0,0)}); end
            2: begin ra1E = 0; dstM = 0; dstW = 0; sbQ.push_back('{"fwdaE_r0", ev(0,0,0,0,0,0,0,0,0,0,0,0,0)}); end
            3: begin
               ra2E = 9; dstW = 9; ra1D = 7; ra2D = 7;
               sbQ.push_back('{"fwd_b_and_d", ev(0,0,0,0,0,0,0,0,2,1,1,1,0)});
            end
            4: begin
               ldM = 1; ra1D = 7;
               sbQ.push_back('{"fwdD_load_blocked", ev(0,0,0,0,0,0,0,0,2,0,0,0,0)});
            end
            default: begin
               d_wait = 1; ra1D = 7;
               sbQ.push_back('{"fwd_off_dwait", ev(1,1,1,1,0,0,0,1,0,0,0,0,0)});
            end
         endcase
         #2;
         e = sbQ.pop_front();
         nCmp++;
         if (obsV !== e.v) begin
            nErr++;
            $display("FAIL %s: got %b want %b", e.name, obsV, e.v);
         end
      end
      clear_inputs();
   endtask

   // I-cache miss with and without a branch waiting in D.
   task automatic test_iwait();
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         clear_inputs();
         i_wait = 1;
         if (i == 0) begin
            sbQ.push_back('{"iwait_plain", ev(1,0,0,0,1,0,0,0,0,0,0,0,0)});
         end else begin
            branchD = 1;
            sbQ.push_back('{"iwait_branch", ev(1,1,0,0,0,1,0,0,0,0,0,0,0)});
         end
         #2;
         e = sbQ.pop_front();
         nCmp++;
         if (obsV !== e.v) begin
            nErr++;
            $display("FAIL %s: got %b want %b", e.name, obsV, e.v);
         end
      end
      clear_inputs();
   endtask

   // Reset asserted mid-BUSY returns to IDLE at once, no residual stall.
   task automatic test_reset_mid_busy();
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         case (i)
            0: begin mdE = 1; sbQ.push_back('{"rb_launch", ev(1,1,1,0,0,0,1,0,0,0,0,0,0)}); #2; end
            1: begin
               #2;
               resetn = 1'b0;
               #1;
               sbQ.push_back('{"rb_in_reset", ev(0,0,0,0,0,0,0,0,0,0,0,0,0)});
            end
            2: begin mdE = 0; resetn = 1'b1; sbQ.push_back('{"rb_released", ev(0,0,0,0,0,0,0,0,0,0,0,0,0)}); #2; end
            default: begin sbQ.push_back('{"rb_next", ev(0,0,0,0,0,0,0,0,0,0,0,0,0)}); #2; end
         endcase
         e = sbQ.pop_front();
         nCmp++;
         if (obsV !== e.v) begin
            nErr++;
            $display("FAIL %s: got %b want %b", e.name, obsV, e.v);
         end
      end
   endtask

   // Counter: clear, 20 stall cycles saturate at 15, clear beats increment.
   task automatic test_stall_counter();
      cntExp_t c;
      int      k;
      @(negedge clk);
      clear_inputs();
      cnt_clr = 1;
      for (k = 1; k <= 23; k++) begin
         @(negedge clk);
         cnt_clr = (k == 21);
         i_wait  = (k <= 21);
         if (k >= 22)      cntQ.push_back('{$sformatf("cnt_k%0d", k), 4'd0});
         else if (k > 16)  cntQ.push_back('{$sformatf("cnt_k%0d", k), 4'd15});
         else              cntQ.push_back('{$sformatf("cnt_k%0d", k), 4'(k - 1)});
         #2;
         c = cntQ.pop_front();
         nCmp++;
         if (stall_cnt !== c.v) begin
            nErr++;
            $display("FAIL %s: got %0d want %0d", c.name, stall_cnt, c.v);
         end
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_md_interlock();
      test_md_dwait();
      test_excp();
      test_data_hazard();
      test_forward();
      test_iwait();
      test_reset_mid_busy();
      test_stall_counter();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
